// File: rtl/sequenciador_passos.sv
// Step sequencer: on Start walks Passo from 0 to ULTIMO, one step per clock, then holds Pronto until Ack.
// Optional feature: define SEQUENCIADOR_ABORT_EN to add the Abort input that cancels a running sequence.
module sequenciador_passos #(
    parameter int unsigned ULTIMO = 7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Ack,
`ifdef SEQUENCIADOR_ABORT_EN
    input  logic       Abort,
`endif
    output logic [2:0] Passo,
    output logic       Ativo,
    output logic       Ultimo,
    output logic       Pronto,
    output logic       Ocupado,
    output logic [1:0] Estado
);

    // Handshake: Start is a level request taken only in OCIOSO; Pronto stays high in FIM
    // until Ack is seen there. A request or Ack arriving in any other state is dropped, not queued.
    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        FIM      = 2'b10,
        INVALIDO = 2'b11
    } estado_t;

    localparam logic [2:0] ULTIMO_P = 3'(ULTIMO);

    estado_t    estado_q, estado_d;
    logic [2:0] passo_q, passo_d;
    logic       limpa, habilita;
    logic       cancela;

`ifdef SEQUENCIADOR_ABORT_EN
    assign cancela = Abort;
`else
    assign cancela = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        limpa    = 1'b0;
        habilita = 1'b0;
        case (estado_q)
            OCIOSO: begin
                limpa = 1'b1;
                if (Start) begin
                    estado_d = CONTANDO;
                end
            end
            CONTANDO: begin
                if (cancela) begin
                    estado_d = OCIOSO;
                    limpa    = 1'b1;
                end else if (passo_q == ULTIMO_P) begin
                    estado_d = FIM;
                end else begin
                    habilita = 1'b1;
                end
            end
            FIM: begin
                if (cancela || Ack) begin
                    estado_d = OCIOSO;
                    limpa    = 1'b1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                limpa    = 1'b1;
            end
        endcase
    end

    // Step counter: clear dominates enable; it never wraps because the FSM stops at ULTIMO.
    always_comb begin
        passo_d = passo_q;
        if (limpa) begin
            passo_d = 3'd0;
        end else if (habilita) begin
            passo_d = passo_q + 3'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            passo_q <= 3'd0;
        end else begin
            passo_q <= passo_d;
        end
    end

    always_comb begin
        Passo   = passo_q;
        Ativo   = (estado_q == CONTANDO);
        Ultimo  = (estado_q == CONTANDO) && (passo_q == ULTIMO_P);
        Pronto  = (estado_q == FIM);
        Ocupado = (estado_q != OCIOSO);
        Estado  = estado_q;
    end

endmodule

// File: tb/tb_sequenciador_passos.sv
// Bench for sequenciador_passos: three instances (ULTIMO 7, 3, 0) share stimulus and are
// compared cycle by cycle against a timestamp model of each run.
module tb_sequenciador_passos;

  logic Clk;
  logic Reset;
  logic Start;
  logic Ack;
  logic Abort;

  logic [2:0] passo7, passo3, passo0;
  logic ativo7, ativo3, ativo0;
  logic ultimo7, ultimo3, ultimo0;
  logic pronto7, pronto3, pronto0;
  logic ocupado7, ocupado3, ocupado0;
  logic [1:0] est7, est3, est0;

  logic [8:0] act7, act3, act0;
  assign act7 = {est7, passo7, ativo7, ultimo7, pronto7, ocupado7};
  assign act3 = {est3, passo3, ativo3, ultimo3, pronto3, ocupado3};
  assign act0 = {est0, passo0, ativo0, ultimo0, pronto0, ocupado0};

  sequenciador_passos #(.ULTIMO(7)) dut7 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
`ifdef SEQUENCIADOR_ABORT_EN
    .Abort(Abort),
`endif
    .Passo(passo7), .Ativo(ativo7), .Ultimo(ultimo7), .Pronto(pronto7),
    .Ocupado(ocupado7), .Estado(est7)
  );

  sequenciador_passos #(.ULTIMO(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
`ifdef SEQUENCIADOR_ABORT_EN
    .Abort(Abort),
`endif
    .Passo(passo3), .Ativo(ativo3), .Ultimo(ultimo3), .Pronto(pronto3),
    .Ocupado(ocupado3), .Estado(est3)
  );

  sequenciador_passos #(.ULTIMO(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
`ifdef SEQUENCIADOR_ABORT_EN
    .Abort(Abort),
`endif
    .Passo(passo0), .Ativo(ativo0), .Ultimo(ultimo0), .Pronto(pronto0),
    .Ocupado(ocupado0), .Estado(est0)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // reference model: each run is a start timestamp; the step is elapsed cycles
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  int ult [3] = '{7, 3, 0};
  int ph  [3] = '{P_IDLE, P_IDLE, P_IDLE};
  int kst [3] = '{0, 0, 0};
  int cyc = 0;

  logic [8:0] exp_q7[$];
  logic [8:0] exp_q3[$];
  logic [8:0] exp_q0[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at t=%0t: got est=%0d passo=%0d ativo=%0b ultimo=%0b pronto=%0b ocupado=%0b, expected est=%0d passo=%0d ativo=%0b ultimo=%0b pronto=%0b ocupado=%0b",
               name, $time, act[8:7], act[6:4], act[3], act[2], act[1], act[0],
               exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] exp_vec(input int i);
    int n;
    n = cyc - kst[i];
    case (ph[i])
      P_RUN:   exp_vec = {2'b01, 3'(n), 1'b1, (n == ult[i]), 1'b0, 1'b1};
      P_DONE:  exp_vec = {2'b10, 3'(ult[i]), 1'b0, 1'b0, 1'b1, 1'b1};
      default: exp_vec = 9'd0;
    endcase
  endfunction

  task automatic model_step();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (Reset) begin
        ph[i] = P_IDLE;
      end else if (ph[i] == P_IDLE) begin
        if (Start) begin
          ph[i]  = P_RUN;
          kst[i] = cyc;
        end
      end else if (ph[i] == P_RUN) begin
        if (Abort) ph[i] = P_IDLE;
        else if (cyc - 1 - kst[i] == ult[i]) ph[i] = P_DONE;
      end else begin
        if (Abort || Ack) ph[i] = P_IDLE;
      end
    end
    exp_q7.push_back(exp_vec(0));
    exp_q3.push_back(exp_vec(1));
    exp_q0.push_back(exp_vec(2));
  endtask

  // driver: one clock edge; inputs are changed only after this returns
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // monitor: every cycle is an output beat; reset overrides everything to zero
  always @(negedge Clk) begin
    logic [8:0] e;
    if (exp_q7.size() > 0) begin
      e = exp_q7.pop_front();
      if (Reset) e = 9'd0;
      check("u7_cycle", act7, e);
    end
    if (exp_q3.size() > 0) begin
      e = exp_q3.pop_front();
      if (Reset) e = 9'd0;
      check("u3_cycle", act3, e);
    end
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      if (Reset) e = 9'd0;
      check("u0_cycle", act0, e);
    end
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Ack   = 1'b0;
    Abort = 1'b0;
    #1;
    check("reset_u7_t0", act7, 9'd0);
    ticks(3);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Reset = 1'b0;
    ticks(2);

    // full run with stray Start during counting and while Pronto waits
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ticks(3);
    Start = 1'b1;
    ticks(2);
    Start = 1'b0;
    ticks(4);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ticks(4);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    ticks(3);

    // asynchronous reset while dut7 shows Passo=4
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ticks(4);
    #1 Reset = 1'b1;
    #1;
    check("async_reset_u7", act7, 9'd0);
    check("async_reset_u3", act3, 9'd0);
    check("async_reset_u0", act0, 9'd0);
    Start = 1'b1;
    ticks(2);
    Start = 1'b0;
    Reset = 1'b0;
    ticks(4);

    // Start and Ack together in FIM: return to idle only
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ticks(9);
    Start = 1'b1;
    Ack   = 1'b1;
    tick();
    Start = 1'b0;
    Ack   = 1'b0;
    ticks(4);

`ifdef SEQUENCIADOR_ABORT_EN
    // abort at Passo=2, then abort together with Ack in FIM
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ticks(2);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    ticks(12);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ticks(9);
    Abort = 1'b1;
    Ack   = 1'b1;
    tick();
    Abort = 1'b0;
    Ack   = 1'b0;
    ticks(2);
    Abort = 1'b1;
    Start = 1'b1;
    tick();
    Abort = 1'b0;
    Start = 1'b0;
    ticks(10);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      Ack   = ($urandom_range(0, 2) == 0);
`ifdef SEQUENCIADOR_ABORT_EN
      Abort = ($urandom_range(0, 15) == 0);
`endif
      Reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    Start = 1'b0;
    Ack   = 1'b0;
    Abort = 1'b0;
    Reset = 1'b0;
    ticks(2);
    @(negedge Clk);
    #1;
    n_checks++;
    if (exp_q7.size() + exp_q3.size() + exp_q0.size() == 0) n_pass++;
    else $display("FAIL queue_drain: %0d entries left, expected 0",
                  exp_q7.size() + exp_q3.size() + exp_q0.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_passos.md
SEQUENCIADOR_PASSOS -- requirements
Module: sequenciador_passos

Interface
REQ-001 SHALL have parameter ULTIMO, default 7, giving the index of the last step (legal range 0..7).
REQ-002 SHALL have port Clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request to run one step sequence; sampled only in state OCIOSO.
REQ-005 SHALL have port Ack  input  1  acknowledgement of Pronto; sampled only in state FIM.
REQ-006 SHALL have port Abort  input  1  cancels a running sequence; present only when ABORT_EN is defined.
REQ-007 SHALL have port Passo  output  3  current step index driven to the datapath.
REQ-008 SHALL have port Ativo  output  1  high while a step is being executed (state CONTANDO).
REQ-009 SHALL have port Ultimo  output  1  high during the cycle executing step ULTIMO.
REQ-010 SHALL have port Pronto  output  1  sequence complete, held until acknowledged (state FIM).
REQ-011 SHALL have port Ocupado  output  1  high in any state other than OCIOSO.

Function
REQ-012 SHALL implement three states with encoding OCIOSO=00, CONTANDO=01, FIM=10; code 11 SHALL transition to OCIOSO on the next edge.
REQ-013 SHALL hold the step index in a 3-bit synchronous counter built from D flip-flops with increment-by-one logic, plus clear and enable controls.
REQ-014 In OCIOSO: Start=1 -> CONTANDO at the next edge with Passo=0; otherwise remain in OCIOSO with Passo=0.
REQ-015 In CONTANDO: if Passo != ULTIMO, Passo increments by one per edge; if Passo == ULTIMO, next state is FIM and Passo holds ULTIMO.
REQ-016 Passo SHALL never wrap; with ULTIMO=7, the transition from 7 goes to FIM, never to 0.
REQ-017 Latency: if Start is sampled at edge k, Ativo=1 from edge k to edge k+ULTIMO+1 (exactly ULTIMO+1 active cycles) and Pronto rises at edge k+ULTIMO+1.
REQ-018 ULTIMO=0: exactly one active cycle with Passo=0 and Ultimo=1, then FIM.
REQ-019 In FIM: Ack=1 -> OCIOSO at the next edge with Passo cleared to 0; Ack=0 -> remain in FIM with Pronto=1.
REQ-020 Start SHALL be ignored in CONTANDO and FIM; Start and Ack both high in FIM -> OCIOSO only, and a new run requires Start in OCIOSO.
REQ-021 Ack SHALL be ignored outside FIM.
REQ-022 Outputs SHALL be decoded from state and counter only (Moore); Ultimo = Ativo AND (Passo == ULTIMO).

Reset
REQ-023 Reset=1 SHALL asynchronously force state OCIOSO and Passo=0, independent of Clk.
REQ-024 While Reset=1: Ativo=0, Ultimo=0, Pronto=0, Ocupado=0; Start is ignored.
REQ-025 Reset asserted mid-sequence SHALL abort it; no Pronto is produced for that sequence.

Configuration
REQ-026 Macro SEQUENCIADOR_ABORT_EN defined: port Abort exists; Abort=1 in CONTANDO or FIM -> OCIOSO at the next edge, Passo=0, no Pronto pulse for the aborted run; Abort has priority over Ack and counting; Abort is ignored in OCIOSO, and Start is still accepted there.
REQ-027 Macro SEQUENCIADOR_ABORT_EN undefined: no Abort port; a sequence ends only by completion+Ack or by Reset.

Verification
REQ-028 ULTIMO=7, Start pulse at edge 1 -> Passo 0..7 at edges 1..8, Ultimo=1 only at Passo=7, Pronto=1 from edge 9 until Ack.
REQ-029 Pronto held 5 cycles with Ack=0, then Ack=1 -> OCIOSO next edge, Passo=0, Ocupado=0; Start during CONTANDO/FIM has no effect.
REQ-030 ULTIMO=0 and ULTIMO=3 -> exactly 1 and 4 Ativo cycles respectively, each with a single Ultimo cycle.
REQ-031 Reset asserted asynchronously at Passo=4 (between edges) -> outputs zero immediately; after release, idle until Start.
REQ-032 SEQUENCIADOR_ABORT_EN defined, Abort=1 at Passo=2 -> OCIOSO next edge, Pronto never asserts; Abort with Ack in FIM -> OCIOSO.
REQ-033 Start and Ack both high in FIM -> OCIOSO; a new run begins only on a later Start.
